// File: rtl/rv64g_l1_refill_responder_pkg.sv
// Purpose: shared TileLink codes, line geometry and FSM state type for the L1 refill responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rv64g_l1_refill_responder_pkg;

    // Line geometry: one 64 B line moves as eight 8 B beats.
    localparam int LINE_BYTES     = 64;
    localparam int BEAT_BYTES     = 8;
    localparam int BEATS_PER_LINE = LINE_BYTES / BEAT_BYTES;
    localparam int LINE_OFF_W     = 6;

    // TileLink channel A / D opcodes.
    localparam logic [2:0] TL_A_ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] TL_D_GRANT         = 3'd4;
    localparam logic [2:0] TL_D_GRANT_DATA    = 3'd5;

    // Grow codes carried in a_param, cap codes carried in d_param.
    localparam logic [2:0] TL_GROW_NTOB = 3'd0;
    localparam logic [2:0] TL_GROW_NTOT = 3'd1;
    localparam logic [1:0] TL_CAP_TOT   = 2'd0;
    localparam logic [1:0] TL_CAP_TOB   = 2'd1;

    // a_size is log2 of the transfer size in bytes.
    localparam logic [3:0] TL_SIZE_LINE = 4'(LINE_OFF_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_DATA,
        ST_ACK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rv64g_l1_refill_responder.sv
// Purpose: accepts one line-refill request, runs a TileLink AcquireBlock/GrantData/GrantAck exchange,
//          and streams each granted beat into the L1 data-array fill port.
// Latency: req@N -> A@N+1 -> beats@N+2..N+9 -> E@N+10 -> done@N+11 when all handshakes are ready.
// Backpressure: A and E hold until ready; d_ready_o is high only while collecting beats.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   refill_req_i/addr_i            request pulse + byte address (sampled only when idle)
//   refill_done_o/err_o            one-cycle completion pulse and its error flag
//   a_*                            TileLink channel A (AcquireBlock) master side
//   d_*                            TileLink channel D (Grant/GrantData) slave side
//   e_*                            TileLink channel E (GrantAck) master side
//   fill_*                         data-array write port: one beat per fill_we_o, commit on last beat
module rv64g_l1_refill_responder
    import rv64g_l1_refill_responder_pkg::*;
#(
    parameter int         TAG_W     = 53,
    parameter int         INDEX_W   = 5,
    parameter int         SOURCE_W  = 4,
    parameter int         SINK_W    = 4,
    parameter int         SOURCE_ID = 0,
    parameter logic [2:0] ACQ_PARAM = TL_GROW_NTOT
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                refill_req_i,
    input  logic [63:0]         refill_addr_i,
    output logic                refill_done_o,
    output logic                refill_err_o,

    output logic                a_valid_o,
    input  logic                a_ready_i,
    output logic [2:0]          a_opcode_o,
    output logic [2:0]          a_param_o,
    output logic [3:0]          a_size_o,
    output logic [SOURCE_W-1:0] a_source_o,
    output logic [63:0]         a_address_o,

    input  logic                d_valid_i,
    output logic                d_ready_o,
    input  logic [2:0]          d_opcode_i,
    input  logic [1:0]          d_param_i,
    input  logic [SINK_W-1:0]   d_sink_i,
    input  logic                d_denied_i,
    input  logic                d_corrupt_i,
    input  logic [63:0]         d_data_i,

    output logic                e_valid_o,
    input  logic                e_ready_i,
    output logic [SINK_W-1:0]   e_sink_o,

    output logic                fill_we_o,
    output logic [INDEX_W-1:0]  fill_index_o,
    output logic [TAG_W-1:0]    fill_tag_o,
    output logic [2:0]          fill_beat_o,
    output logic [63:0]         fill_data_o,
    output logic                fill_commit_o,
    output logic                fill_perm_o
);

    localparam int LINE_W = 64 - LINE_OFF_W;
    localparam logic [SOURCE_W-1:0] SRC_ID = SOURCE_W'(SOURCE_ID);

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_q;
    logic [2:0]          beat_q;
    logic                err_q;
    logic                perm_q;
    logic [SINK_W-1:0]   sink_q;

    logic                beat_fire;
    logic                first_beat;
    logic                last_beat;
    logic                err_next;

    // Byte offset within the line is irrelevant: the whole line is always fetched.
    logic                unused_addr_off;
    assign unused_addr_off = ^refill_addr_i[LINE_OFF_W-1:0];

    assign beat_fire  = (state_q == ST_DATA) && d_valid_i;
    // The counter only leaves 0 once a beat is taken, so 0 in DATA identifies the first beat.
    assign first_beat = (beat_q == 3'd0);
    // A dataless Grant is a complete response in one beat; anything else counts as a data beat.
    assign last_beat  = (d_opcode_i == TL_D_GRANT) || (beat_q == 3'(BEATS_PER_LINE - 1));
    // A dataless Grant still ends in error: this responder only ever asks for data.
    assign err_next   = err_q | d_denied_i | d_corrupt_i | (d_opcode_i != TL_D_GRANT_DATA);

    always_comb begin
        state_d       = state_q;
        refill_done_o = 1'b0;
        refill_err_o  = 1'b0;
        a_valid_o     = 1'b0;
        a_opcode_o    = 3'd0;
        a_param_o     = 3'd0;
        a_size_o      = 4'd0;
        a_source_o    = '0;
        a_address_o   = 64'd0;
        d_ready_o     = 1'b0;
        e_valid_o     = 1'b0;
        e_sink_o      = '0;
        fill_we_o     = 1'b0;
        fill_index_o  = '0;
        fill_tag_o    = '0;
        fill_beat_o   = 3'd0;
        fill_data_o   = 64'd0;
        fill_commit_o = 1'b0;
        fill_perm_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (refill_req_i) begin
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ: begin
                a_valid_o   = 1'b1;
                a_opcode_o  = TL_A_ACQUIRE_BLOCK;
                a_param_o   = ACQ_PARAM;
                a_size_o    = TL_SIZE_LINE;
                a_source_o  = SRC_ID;
                a_address_o = {line_q, {LINE_OFF_W{1'b0}}};
                if (a_ready_i) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                d_ready_o    = 1'b1;
                fill_index_o = line_q[INDEX_W-1:0];
                fill_tag_o   = line_q[INDEX_W +: TAG_W];
                fill_beat_o  = beat_q;
                fill_data_o  = d_data_i;
                // On the first beat the cap is taken straight from D so the port is valid
                // before the latched copy exists.
                fill_perm_o  = first_beat ? (d_param_i == TL_CAP_TOT) : perm_q;
                if (d_valid_i) begin
                    fill_we_o = !d_denied_i;
                    if (last_beat) begin
                        fill_commit_o = !err_next;
                        state_d       = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                e_valid_o = 1'b1;
                e_sink_o  = sink_q;
                if (e_ready_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                refill_done_o = 1'b1;
                refill_err_o  = err_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            beat_q  <= 3'd0;
            err_q   <= 1'b0;
            perm_q  <= 1'b0;
            sink_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && refill_req_i) begin
                line_q <= refill_addr_i[63:LINE_OFF_W];
                beat_q <= 3'd0;
                err_q  <= 1'b0;
            end
            if (beat_fire) begin
                beat_q <= beat_q + 3'd1;
                err_q  <= err_next;
                if (first_beat) begin
                    sink_q <= d_sink_i;
                    perm_q <= (d_param_i == TL_CAP_TOT);
                end
            end
        end
    end

endmodule

// File: tb/tb_rv64g_l1_refill_responder.sv
// Purpose: directed self-checking bench for rv64g_l1_refill_responder.
// Latency: checks the ready-path timing req@N .. done@N+11 and stalled variants.
// Backpressure: exercises A/E stalls and D valid gaps.
module tb_rv64g_l1_refill_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refill_req;
    logic [63:0] refill_addr;
    logic        refill_done, refill_err;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_sink;
    logic        d_denied, d_corrupt;
    logic [63:0] d_data;
    logic        e_valid, e_ready;
    logic [3:0]  e_sink;
    logic        fill_we;
    logic [4:0]  fill_index;
    logic [52:0] fill_tag;
    logic [2:0]  fill_beat;
    logic [63:0] fill_data;
    logic        fill_commit, fill_perm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv64g_l1_refill_responder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .refill_req_i  (refill_req),
        .refill_addr_i (refill_addr),
        .refill_done_o (refill_done),
        .refill_err_o  (refill_err),
        .a_valid_o     (a_valid),
        .a_ready_i     (a_ready),
        .a_opcode_o    (a_opcode),
        .a_param_o     (a_param),
        .a_size_o      (a_size),
        .a_source_o    (a_source),
        .a_address_o   (a_address),
        .d_valid_i     (d_valid),
        .d_ready_o     (d_ready),
        .d_opcode_i    (d_opcode),
        .d_param_i     (d_param),
        .d_sink_i      (d_sink),
        .d_denied_i    (d_denied),
        .d_corrupt_i   (d_corrupt),
        .d_data_i      (d_data),
        .e_valid_o     (e_valid),
        .e_ready_i     (e_ready),
        .e_sink_o      (e_sink),
        .fill_we_o     (fill_we),
        .fill_index_o  (fill_index),
        .fill_tag_o    (fill_tag),
        .fill_beat_o   (fill_beat),
        .fill_data_o   (fill_data),
        .fill_commit_o (fill_commit),
        .fill_perm_o   (fill_perm)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_valid"},  a_valid, 0);
        chk({tag, "_a_addr"},   a_address, 0);
        chk({tag, "_d_ready"},  d_ready, 0);
        chk({tag, "_e_valid"},  e_valid, 0);
        chk({tag, "_fill_we"},  fill_we, 0);
        chk({tag, "_commit"},   fill_commit, 0);
        chk({tag, "_done"},     refill_done, 0);
        chk({tag, "_err"},      refill_err, 0);
    endtask

    // One full GrantData refill. Expected index/tag/address are passed in as hand-computed constants.
    task automatic do_refill(input string tag, input logic [63:0] addr, input logic [63:0] exp_a_addr,
                             input logic [4:0] exp_idx, input logic [52:0] exp_tag,
                             input int a_stall, input bit gaps, input int e_stall,
                             input int bad_beat, input bit exp_err, input bit poke_req);
        logic [63:0] pat;
        refill_req  = 1'b1;
        refill_addr = addr;
        a_ready     = (a_stall == 0);
        smp();
        chk({tag, "_idle_a_valid"}, a_valid, 0);
        tick();
        refill_req  = 1'b0;
        refill_addr = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int s = 0; s < a_stall; s++) begin
            smp();
            chk({tag, "_astall_valid"}, a_valid, 1);
            chk({tag, "_astall_addr"},  a_address, exp_a_addr);
            chk({tag, "_astall_dready"}, d_ready, 0);
            tick();
        end
        a_ready = 1'b1;
        smp();
        chk({tag, "_a_valid"},  a_valid, 1);
        chk({tag, "_a_addr"},   a_address, exp_a_addr);
        chk({tag, "_a_opcode"}, a_opcode, 6);
        chk({tag, "_a_size"},   a_size, 6);
        chk({tag, "_a_param"},  a_param, 1);
        chk({tag, "_a_source"}, a_source, 0);
        chk({tag, "_a_dready"}, d_ready, 0);
        tick();
        a_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (gaps && i[0]) begin
                d_valid = 1'b0;
                if (poke_req && i == 3) begin
                    refill_req  = 1'b1;
                    refill_addr = 64'h0000_0000_0000_07C0;
                end
                smp();
                chk({tag, "_gap_we"},    fill_we, 0);
                chk({tag, "_gap_dready"}, d_ready, 1);
                tick();
                refill_req = 1'b0;
            end
            pat       = 64'hA5A5_0000_0000_0000 | (64'h0101 * (i + 1));
            d_valid   = 1'b1;
            d_opcode  = 3'd5;
            d_param   = 2'd0;
            d_sink    = 4'hA;
            d_denied  = 1'b0;
            d_corrupt = (i == bad_beat);
            d_data    = pat;
            smp();
            chk({tag, "_we"},     fill_we, 1);
            chk({tag, "_beat"},   fill_beat, 64'(i));
            chk({tag, "_data"},   fill_data, pat);
            chk({tag, "_index"},  fill_index, exp_idx);
            chk({tag, "_tag"},    fill_tag, exp_tag);
            chk({tag, "_perm"},   fill_perm, 1);
            chk({tag, "_commit"}, fill_commit, (i == 7 && !exp_err) ? 1 : 0);
            tick();
        end
        d_valid   = 1'b0;
        d_corrupt = 1'b0;
        e_ready   = (e_stall == 0);
        for (int s = 0; s < e_stall; s++) begin
            smp();
            chk({tag, "_estall_valid"}, e_valid, 1);
            chk({tag, "_estall_sink"},  e_sink, 4'hA);
            chk({tag, "_estall_done"},  refill_done, 0);
            chk({tag, "_estall_we"},    fill_we, 0);
            tick();
        end
        e_ready = 1'b1;
        smp();
        chk({tag, "_e_valid"}, e_valid, 1);
        chk({tag, "_e_sink"},  e_sink, 4'hA);
        chk({tag, "_e_done"},  refill_done, 0);
        tick();
        e_ready = 1'b0;
        smp();
        chk({tag, "_done"},     refill_done, 1);
        chk({tag, "_done_err"}, refill_err, exp_err ? 1 : 0);
        chk({tag, "_done_ev"},  e_valid, 0);
        tick();
        smp();
        chk({tag, "_done_once"}, refill_done, 0);
        chk({tag, "_back_idle"}, a_valid, 0);
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        refill_req  = 1'b0;
        refill_addr = 64'd0;
        a_ready     = 1'b0;
        d_valid     = 1'b0;
        d_opcode    = 3'd0;
        d_param     = 2'd0;
        d_sink      = 4'd0;
        d_denied    = 1'b0;
        d_corrupt   = 1'b0;
        d_data      = 64'd0;
        e_ready     = 1'b0;

        // Reset state: every output low even with ready inputs asserted.
        tick();
        a_ready = 1'b1;
        e_ready = 1'b1;
        smp();
        chk_all_zero("rst");
        tick();
        rst_n   = 1'b1;
        a_ready = 1'b0;
        e_ready = 1'b0;

        // Idle with no request: nothing moves.
        smp();
        chk_all_zero("idle");
        tick();

        // Nominal refill, every handshake ready.
        do_refill("nom", 64'h0000_0000_8000_1040, 64'h0000_0000_8000_1040,
                  5'd1, 53'h10_0002, 0, 1'b0, 0, -1, 1'b0, 1'b0);

        // Stalled A, gapped D with a stray request mid-data, stalled E; unaligned address.
        do_refill("stall", 64'h0000_0000_1234_5FC7, 64'h0000_0000_1234_5FC0,
                  5'h1F, 53'h2_468B, 5, 1'b1, 3, -1, 1'b0, 1'b1);

        // Corrupt beat 3: all beats written, no commit, error reported.
        do_refill("corrupt", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0,
                  5'h1F, 53'h1F_FFFF_FFFF_FFFF, 0, 1'b0, 0, 3, 1'b1, 1'b0);

        // Dataless Grant, denied: no write, no commit, GrantAck with sink, error done.
        refill_req  = 1'b1;
        refill_addr = 64'h0000_0000_0000_0040;
        a_ready     = 1'b1;
        tick();
        refill_req  = 1'b0;
        smp();
        chk("grant_a_addr", a_address, 64'h40);
        tick();
        d_valid  = 1'b1;
        d_opcode = 3'd4;
        d_param  = 2'd1;
        d_sink   = 4'h5;
        d_denied = 1'b1;
        smp();
        chk("grant_dready", d_ready, 1);
        chk("grant_we",     fill_we, 0);
        chk("grant_commit", fill_commit, 0);
        chk("grant_perm",   fill_perm, 0);
        tick();
        d_valid  = 1'b0;
        d_denied = 1'b0;
        smp();
        chk("grant_e_valid", e_valid, 1);
        chk("grant_e_sink",  e_sink, 4'h5);
        chk("grant_dready_off", d_ready, 0);
        e_ready = 1'b1;
        tick();
        e_ready = 1'b0;
        smp();
        chk("grant_done", refill_done, 1);
        chk("grant_err",  refill_err, 1);
        tick();

        // Reset during beat 4: outputs drop at once, no done pulse, next refill restarts at beat 0.
        refill_req  = 1'b1;
        refill_addr = 64'h0000_0000_8000_1040;
        a_ready     = 1'b1;
        tick();
        refill_req  = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            d_valid  = 1'b1;
            d_opcode = 3'd5;
            d_param  = 2'd0;
            d_sink   = 4'h3;
            d_data   = 64'(i);
            tick();
        end
        smp();
        chk("rst4_pre_beat", fill_beat, 4);
        chk("rst4_pre_we",   fill_we, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst4");
        tick();
        smp();
        chk("rst4_hold_done", refill_done, 0);
        tick();
        rst_n   = 1'b1;
        d_valid = 1'b0;
        a_ready = 1'b0;
        smp();
        chk_all_zero("rst4_rel");
        tick();
        do_refill("restart", 64'h0000_0000_8000_1040, 64'h0000_0000_8000_1040,
                  5'd1, 53'h10_0002, 0, 1'b0, 0, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends with a summary line.
    initial begin
        #50000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
